// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared constants for the serial 7-segment display receiver:
//   NUM_DIGITS  - digits multiplexed by the scanner
//   SEG_W       - segment bits per digit (7 segments + decimal point)
//   FRAME_BITS  - bits per serial frame (one byte per digit)
//   RX_*        - receiver state encoding
//   digit_onehot() - digit index to one-hot digit enable
// ---------------------------------------------------------------------------
package display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEG_W      = 8;
    localparam int FRAME_BITS = NUM_DIGITS * SEG_W;
    localparam int IDX_W      = $clog2(FRAME_BITS);
    localparam int DIGIT_W    = $clog2(NUM_DIGITS);

    // Receiver state enumeration
    localparam logic [1:0] RX_IDLE     = 2'd0;
    localparam logic [1:0] RX_SHIFT    = 2'd1;
    localparam logic [1:0] RX_WAIT_LOW = 2'd2;

    function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [DIGIT_W-1:0] k);
        return NUM_DIGITS'(1) << k;
    endfunction

endpackage

// File: rtl/display_scan.sv
// ---------------------------------------------------------------------------
// display_scan
// Free-running digit multiplexer. A divider counts 0..SCAN_DIV-1; on each
// wrap the digit index advances 0->1->2->3->0. seg carries the latch byte of
// the selected digit, registered so that it changes on the same edge as
// digit_sel.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   latch [31:0]       - display word, digit k uses bits [8k+7:8k]
//   seg [7:0]          - segment pattern of the selected digit
//   digit_sel [3:0]    - one-hot active-high digit enable
// ---------------------------------------------------------------------------
module display_scan
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [FRAME_BITS-1:0] latch,
    output logic [SEG_W-1:0]      seg,
    output logic [NUM_DIGITS-1:0] digit_sel
);

    localparam int DIV_W = $clog2(SCAN_DIV);

    logic [DIV_W-1:0]   div_reg;
    logic [DIGIT_W-1:0] digit_reg;
    logic [DIGIT_W-1:0] digit_next;
    logic [SEG_W-1:0]   seg_reg;
    logic               slot_wrap;
    logic [SEG_W-1:0]   digit_bytes [NUM_DIGITS];

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_bytes
        assign digit_bytes[gi] = latch[gi*SEG_W +: SEG_W];
    end

    assign slot_wrap  = (div_reg == DIV_W'(SCAN_DIV - 1));
    // NUM_DIGITS is a power of two, so the index wraps 3->0 on its own.
    assign digit_next = slot_wrap ? digit_reg + DIGIT_W'(1) : digit_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg   <= '0;
            digit_reg <= '0;
            seg_reg   <= '0;
        end else begin
            div_reg   <= slot_wrap ? '0 : div_reg + DIV_W'(1);
            digit_reg <= digit_next;
            // Sampling the byte of the digit that will be selected after this
            // edge keeps seg aligned with digit_sel, and picks up a latch
            // change one clock later regardless of the slot position.
            seg_reg   <= digit_bytes[digit_next];
        end
    end

    assign seg       = seg_reg;
    assign digit_sel = digit_onehot(digit_reg);

endmodule

// File: rtl/display_rx.sv
// ---------------------------------------------------------------------------
// display_rx
// Serial receiver for a 4-digit multiplexed 7-segment display. 32-bit frames
// arrive LSB first on data_in, one bit per clk cycle with enable=1, framed by
// frame_valid. A complete frame is copied into the display latch one clock
// after its last bit; display_scan multiplexes the latch onto the digits.
// Optional feature (macro DISPLAY_RX_TIMEOUT_EN): blank the display and raise
// stale after TIMEOUT_TICKS enable ticks without a good frame.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   enable            - bit tick
//   data_in           - serial segment bit, LSB first
//   frame_valid       - high while frame bits are present
//   seg [7:0]         - segment pattern of the selected digit
//   digit_sel [3:0]   - one-hot active-high digit enable
//   frame_done        - one-cycle pulse when a frame is latched
//   frame_err         - one-cycle pulse when a frame is aborted
//   stale             - display blanked by timeout (0 without the macro)
// ---------------------------------------------------------------------------
module display_rx
    import display_pkg::*;
#(
    parameter int SCAN_DIV      = 1000,
    parameter int TIMEOUT_TICKS = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  data_in,
    input  logic                  frame_valid,
    output logic [SEG_W-1:0]      seg,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic                  stale
);

    if (SCAN_DIV < 2 || SCAN_DIV > 65535 || TIMEOUT_TICKS < 1) begin : g_param_check
        $error("display_rx: SCAN_DIV or TIMEOUT_TICKS out of range");
    end

    logic [1:0]            state_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [FRAME_BITS-1:0] latch_reg;
    logic                  load_pending_reg;
    logic                  frame_done_reg;
    logic                  frame_err_reg;

    // ------------------------------------------------------------------
    // Deserializer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= RX_IDLE;
            idx_reg          <= '0;
            shift_reg        <= '0;
            load_pending_reg <= 1'b0;
            frame_err_reg    <= 1'b0;
        end else begin
            load_pending_reg <= 1'b0;
            frame_err_reg    <= 1'b0;
            if (enable) begin
                case (state_reg)
                    RX_IDLE: begin
                        if (frame_valid) begin
                            // Start clean so no bits of an older frame survive.
                            shift_reg <= {{(FRAME_BITS-1){1'b0}}, data_in};
                            idx_reg   <= IDX_W'(1);
                            state_reg <= RX_SHIFT;
                        end
                    end
                    RX_SHIFT: begin
                        if (frame_valid) begin
                            shift_reg[idx_reg] <= data_in;
                            idx_reg            <= idx_reg + IDX_W'(1);
                            if (idx_reg == IDX_W'(FRAME_BITS - 1)) begin
                                state_reg        <= RX_WAIT_LOW;
                                load_pending_reg <= 1'b1;
                            end
                        end else begin
                            frame_err_reg <= 1'b1;
                            shift_reg     <= '0;
                            idx_reg       <= '0;
                            state_reg     <= RX_IDLE;
                        end
                    end
                    RX_WAIT_LOW: begin
                        // Extra bits past the frame are ignored, not an error.
                        if (!frame_valid) begin
                            idx_reg   <= '0;
                            state_reg <= RX_IDLE;
                        end
                    end
                    default: begin
                        state_reg <= RX_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Display latch, frame_done and optional timeout
    // ------------------------------------------------------------------
`ifdef DISPLAY_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

    logic [TO_W-1:0] to_cnt_reg;
    logic            stale_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            latch_reg      <= '0;
            frame_done_reg <= 1'b0;
            to_cnt_reg     <= '0;
            stale_reg      <= 1'b0;
        end else begin
            frame_done_reg <= load_pending_reg;
            if (load_pending_reg) begin
                // A good frame wins over a coincident tick.
                latch_reg  <= shift_reg;
                to_cnt_reg <= '0;
                stale_reg  <= 1'b0;
            end else if (enable && to_cnt_reg != TO_W'(TIMEOUT_TICKS)) begin
                to_cnt_reg <= to_cnt_reg + TO_W'(1);
                if (to_cnt_reg == TO_W'(TIMEOUT_TICKS - 1)) begin
                    latch_reg <= '0;
                    stale_reg <= 1'b1;
                end
            end
        end
    end

    assign stale = stale_reg;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            latch_reg      <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= load_pending_reg;
            if (load_pending_reg) begin
                latch_reg <= shift_reg;
            end
        end
    end

    assign stale = 1'b0;
`endif

    assign frame_done = frame_done_reg;
    assign frame_err  = frame_err_reg;

    // ------------------------------------------------------------------
    // Digit scanning
    // ------------------------------------------------------------------
    display_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk       (clk),
        .reset     (reset),
        .latch     (latch_reg),
        .seg       (seg),
        .digit_sel (digit_sel)
    );

endmodule

// File: tb/tb_display_rx.sv
// ---------------------------------------------------------------------------
// tb_display_rx
// Directed bench for display_rx with SCAN_DIV=4 and TIMEOUT_TICKS=16.
// Builds with or without DISPLAY_RX_TIMEOUT_EN; expectations follow the
// macro. Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_display_rx;

    localparam int SCAN_DIV      = 4;
    localparam int TIMEOUT_TICKS = 16;
    localparam int GAP           = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       data_in;
    logic       frame_valid;
    logic [7:0] seg;
    logic [3:0] digit_sel;
    logic       frame_done;
    logic       frame_err;
    logic       stale;

    int tests_run    = 0;
    int tests_failed = 0;
    int done_cnt     = 0;
    int err_cnt      = 0;

    display_rx #(
        .SCAN_DIV      (SCAN_DIV),
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .data_in     (data_in),
        .frame_valid (frame_valid),
        .seg         (seg),
        .digit_sel   (digit_sel),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled once per cycle.
    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    end

    // One enable tick, then GAP-1 idle cycles. Starts and ends on a falling edge.
    task automatic tick(input logic fv, input logic b, input int gap);
        enable      = 1'b1;
        frame_valid = fv;
        data_in     = b;
        @(negedge clk);
        enable  = 1'b0;
        data_in = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    // Full frame followed by one tick with frame_valid low.
    task automatic send_frame(input logic [31:0] word);
        for (int i = 0; i < 32; i++) tick(1'b1, word[i], GAP);
        tick(1'b0, 1'b0, GAP);
        $display("[TB] frame %08h sent", word);
    endtask

    // Observe one scan round starting at digit 0 (observation only).
    task automatic capture(output logic [31:0] word, output logic [15:0] sels, output logic ok);
        word = '0;
        sels = '0;
        for (int i = 0; i < 40; i++) begin
            if (digit_sel === 4'b0001) break;
            @(negedge clk);
        end
        ok = (digit_sel === 4'b0001);
        for (int k = 0; k < 4; k++) begin
            word[8*k +: 8] = seg;
            sels[4*k +: 4] = digit_sel;
            repeat (SCAN_DIV) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b0; data_in = 1'b0; frame_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++; if (seg !== 8'h00) begin tests_failed++; $display("FAIL reset_seg: got %h expected 00", seg); end
        tests_run++; if (digit_sel !== 4'b0001) begin tests_failed++; $display("FAIL reset_digit_sel: got %b expected 0001", digit_sel); end
        tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        tests_run++; if (stale !== 1'b0) begin tests_failed++; $display("FAIL reset_stale: got %b expected 0", stale); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++; if (digit_sel !== 4'b0001) begin tests_failed++; $display("FAIL scan_slot_hold: got %b expected 0001", digit_sel); end
        @(negedge clk);
        tests_run++; if (digit_sel !== 4'b0010) begin tests_failed++; $display("FAIL scan_slot_advance: got %b expected 0010", digit_sel); end
        $display("[TB] reset checked");
    endtask

    task automatic test_basic;
        logic [31:0] word, got;
        logic [15:0] sels;
        logic        ok;
        logic [7:0]  exp_byte;
        int          d0, e0;
        word = 32'hC0F9A4B0;
        d0 = done_cnt; e0 = err_cnt;
        for (int i = 0; i < 31; i++) tick(1'b1, word[i], GAP);
        enable = 1'b1; frame_valid = 1'b1; data_in = word[31];
        @(negedge clk);
        enable = 1'b0; data_in = 1'b0;
        tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL done_early: got %b expected 0", frame_done); end
        @(negedge clk);
        tests_run++; if (frame_done !== 1'b1) begin tests_failed++; $display("FAIL done_latency: got %b expected 1", frame_done); end
        @(negedge clk);
        tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL done_width: got %b expected 0", frame_done); end
        exp_byte = 8'hxx;
        for (int k = 0; k < 4; k++) if (digit_sel === (4'b0001 << k)) exp_byte = word[8*k +: 8];
        tests_run++; if (seg !== exp_byte) begin tests_failed++; $display("FAIL seg_immediate: got %h expected %h", seg, exp_byte); end
        tick(1'b0, 1'b0, GAP);
        $display("[TB] frame %08h sent", word);
        capture(got, sels, ok);
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL basic_scan_found: got %b expected 1", ok); end
        tests_run++; if (got !== word) begin tests_failed++; $display("FAIL basic_display: got %h expected %h", got, word); end
        tests_run++; if (sels !== 16'h8421) begin tests_failed++; $display("FAIL basic_digit_seq: got %h expected 8421", sels); end
        tests_run++; if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt - d0); end
        tests_run++; if (err_cnt - e0 !== 0) begin tests_failed++; $display("FAIL basic_err_count: got %0d expected 0", err_cnt - e0); end
        tests_run++; if (stale !== 1'b0) begin tests_failed++; $display("FAIL basic_stale: got %b expected 0", stale); end
    endtask

    task automatic test_abort;
        logic [31:0] part, word, got, exp_hold;
        logic [15:0] sels;
        logic        ok, exp_stale;
        int          d0, e0;
        part = 32'h12345678;
        word = 32'h5A3C96E1;
`ifdef DISPLAY_RX_TIMEOUT_EN
        exp_hold = 32'h0; exp_stale = 1'b1;
`else
        exp_hold = 32'hC0F9A4B0; exp_stale = 1'b0;
`endif
        d0 = done_cnt; e0 = err_cnt;
        for (int i = 0; i < 20; i++) tick(1'b1, part[i], GAP);
        tick(1'b0, 1'b0, GAP);
        $display("[TB] frame %08h aborted after 20 bits", part);
        tests_run++; if (err_cnt - e0 !== 1) begin tests_failed++; $display("FAIL abort_err_count: got %0d expected 1", err_cnt - e0); end
        tests_run++; if (done_cnt - d0 !== 0) begin tests_failed++; $display("FAIL abort_done_count: got %0d expected 0", done_cnt - d0); end
        capture(got, sels, ok);
        tests_run++; if (got !== exp_hold) begin tests_failed++; $display("FAIL abort_latch_hold: got %h expected %h", got, exp_hold); end
        tests_run++; if (stale !== exp_stale) begin tests_failed++; $display("FAIL abort_stale: got %b expected %b", stale, exp_stale); end
        d0 = done_cnt; e0 = err_cnt;
        send_frame(word);
        capture(got, sels, ok);
        tests_run++; if (got !== word) begin tests_failed++; $display("FAIL abort_next_frame: got %h expected %h", got, word); end
        tests_run++; if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL abort_next_done: got %0d expected 1", done_cnt - d0); end
        tests_run++; if (err_cnt - e0 !== 0) begin tests_failed++; $display("FAIL abort_next_err: got %0d expected 0", err_cnt - e0); end
        tests_run++; if (stale !== 1'b0) begin tests_failed++; $display("FAIL abort_next_stale: got %b expected 0", stale); end
    endtask

    task automatic test_long_frame;
        logic [31:0] word, got;
        logic [15:0] sels;
        logic        ok;
        int          d0, e0;
        word = 32'hDEADBEEF;
        d0 = done_cnt; e0 = err_cnt;
        for (int i = 0; i < 32; i++) tick(1'b1, word[i], GAP);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, GAP);
        tick(1'b0, 1'b0, GAP);
        $display("[TB] frame %08h sent with 40 valid ticks", word);
        tests_run++; if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL long_done_count: got %0d expected 1", done_cnt - d0); end
        tests_run++; if (err_cnt - e0 !== 0) begin tests_failed++; $display("FAIL long_err_count: got %0d expected 0", err_cnt - e0); end
        capture(got, sels, ok);
        tests_run++; if (got !== word) begin tests_failed++; $display("FAIL long_display: got %h expected %h", got, word); end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] word, got;
        logic [15:0] sels;
        logic        ok;
        int          d0, e0;
        word = 32'h0F1E2D3C;
        e0 = err_cnt;
        for (int i = 0; i < 15; i++) tick(1'b1, word[i], GAP);
        reset = 1'b1; enable = 1'b1; frame_valid = 1'b1; data_in = word[15];
        @(negedge clk);
        tests_run++; if (seg !== 8'h00) begin tests_failed++; $display("FAIL midreset_seg: got %h expected 00", seg); end
        tests_run++; if (digit_sel !== 4'b0001) begin tests_failed++; $display("FAIL midreset_digit_sel: got %b expected 0001", digit_sel); end
        tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL midreset_frame_done: got %b expected 0", frame_done); end
        tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL midreset_frame_err: got %b expected 0", frame_err); end
        tests_run++; if (stale !== 1'b0) begin tests_failed++; $display("FAIL midreset_stale: got %b expected 0", stale); end
        enable = 1'b0; frame_valid = 1'b0; data_in = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        $display("[TB] reset asserted at bit 15");
        tests_run++; if (err_cnt - e0 !== 0) begin tests_failed++; $display("FAIL midreset_err_count: got %0d expected 0", err_cnt - e0); end
        capture(got, sels, ok);
        tests_run++; if (got !== 32'h0) begin tests_failed++; $display("FAIL midreset_latch_cleared: got %h expected 00000000", got); end
        d0 = done_cnt;
        send_frame(word);
        capture(got, sels, ok);
        tests_run++; if (got !== word) begin tests_failed++; $display("FAIL midreset_next_frame: got %h expected %h", got, word); end
        tests_run++; if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL midreset_next_done: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_timeout;
        logic [31:0] word, got;
        logic [15:0] sels;
        logic        ok;
        word = 32'h8899AABB;
        send_frame(word);                  // trailing idle tick is tick 1
        for (int i = 0; i < 14; i++) tick(1'b0, 1'b0, GAP);
        tests_run++; if (stale !== 1'b0) begin tests_failed++; $display("FAIL timeout_before: got %b expected 0", stale); end
`ifdef DISPLAY_RX_TIMEOUT_EN
        tick(1'b0, 1'b0, GAP);             // tick 16
        $display("[TB] 16 idle ticks after frame %08h", word);
        tests_run++; if (stale !== 1'b1) begin tests_failed++; $display("FAIL timeout_stale: got %b expected 1", stale); end
        tests_run++; if (seg !== 8'h00) begin tests_failed++; $display("FAIL timeout_seg: got %h expected 00", seg); end
        capture(got, sels, ok);
        tests_run++; if (got !== 32'h0) begin tests_failed++; $display("FAIL timeout_blank: got %h expected 00000000", got); end
        word = 32'h01020304;
        send_frame(word);
        tests_run++; if (stale !== 1'b0) begin tests_failed++; $display("FAIL timeout_restore_stale: got %b expected 0", stale); end
        capture(got, sels, ok);
        tests_run++; if (got !== word) begin tests_failed++; $display("FAIL timeout_restore_display: got %h expected %h", got, word); end
`else
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, GAP);
        $display("[TB] 21 idle ticks after frame %08h", word);
        tests_run++; if (stale !== 1'b0) begin tests_failed++; $display("FAIL no_timeout_stale: got %b expected 0", stale); end
        capture(got, sels, ok);
        tests_run++; if (got !== word) begin tests_failed++; $display("FAIL no_timeout_hold: got %h expected %h", got, word); end
`endif
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; data_in = 1'b0; frame_valid = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_abort();
        test_long_frame();
        test_reset_midframe();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
